// File: rtl/mtc0_pkg.sv
// Shared MTC0 test-status encodings used by the ALU and the status monitor.
package mtc0_pkg;

  typedef enum logic [1:0] {
    MTC0_NOOP = 2'd0,
    MTC0_PASS = 2'd1,
    MTC0_FAIL = 2'd2,
    MTC0_DONE = 2'd3
  } mtc0_code_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } mon_state_e;

  localparam int REPORT_W = 18;

  typedef struct packed {
    logic [1:0]  code;
    logic [15:0] value;
  } report_t;

endpackage

// File: rtl/status_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is driven only from flops.
module status_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic [WIDTH-1:0] i_Data,
  output logic             o_Full,
  output logic             o_Empty,
  output logic             o_One,
  output logic [WIDTH-1:0] o_Head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok, push_ok;

  assign o_Empty = (wr_q == rd_q);
  assign o_Full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_One   = ((wr_q - rd_q) == (AW+1)'(1));
  assign pop_ok  = i_Pop & ~o_Empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = i_Push & (~o_Full | pop_ok);
  assign o_Head  = o_Empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + (AW+1)'(1);
      if (pop_ok)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= i_Data;
  end

endmodule

// File: rtl/test_status_monitor.sv
// Turns MTC0 PASS/FAIL/DONE events into sticky status and an ordered report stream.
module test_status_monitor
  import mtc0_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Valid,
  input  logic                   i_Advance,
  input  logic [1:0]             i_Pass_Done_Change,
  input  logic [15:0]            i_Pass_Done_Value,
  output logic                   o_Report_Valid,
  output logic [1:0]             o_Report_Code,
  output logic [15:0]            o_Report_Value,
  input  logic                   i_Report_Ready,
  output logic [COUNT_WIDTH-1:0] o_Pass_Count,
  output logic [COUNT_WIDTH-1:0] o_Fail_Count,
  output logic                   o_Failed,
  output logic                   o_Overflow,
  output logic                   o_Done,
  output logic                   o_Halt_Req
);
  mon_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] pass_q, pass_d, fail_q, fail_d;
  logic                   failed_q, failed_d, ovf_q, ovf_d, done_q, done_d;
  logic                   accept, pop, full, empty, one;
  report_t                head;

  // Stalled instructions (no advance) are ignored so repeats are never double-counted.
  assign accept = i_Valid & i_Advance & (i_Pass_Done_Change != MTC0_NOOP) & (state_q == ST_RUN);
  assign pop    = o_Report_Valid & i_Report_Ready;

  status_fifo #(.WIDTH(REPORT_W), .DEPTH(DEPTH)) u_fifo (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Push  (accept),
    .i_Pop   (pop),
    .i_Data  ({i_Pass_Done_Change, i_Pass_Done_Value}),
    .o_Full  (full),
    .o_Empty (empty),
    .o_One   (one),
    .o_Head  (head)
  );

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    failed_d = failed_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    if (accept) begin
      if (full && !pop) ovf_d = 1'b1;
      case (i_Pass_Done_Change)
        MTC0_PASS: if (pass_q != '1) pass_d = pass_q + 1'b1;
        MTC0_FAIL: begin
          if (fail_q != '1) fail_d = fail_q + 1'b1;
          failed_d = 1'b1;
        end
        MTC0_DONE: done_d = 1'b1;
        default: ;
      endcase
    end
    case (state_q)
      ST_RUN:    if (accept && i_Pass_Done_Change == MTC0_DONE) state_d = ST_DRAIN;
      // Halt as soon as the FIFO will be empty after this edge.
      ST_DRAIN:  if (empty || (one && pop)) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= ST_RUN;
      pass_q   <= '0;
      fail_q   <= '0;
      failed_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      failed_q <= failed_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign o_Report_Valid = ~empty;
  assign o_Report_Code  = head.code;
  assign o_Report_Value = head.value;
  assign o_Pass_Count   = pass_q;
  assign o_Fail_Count   = fail_q;
  assign o_Failed       = failed_q;
  assign o_Overflow     = ovf_q;
  assign o_Done         = done_q;
  assign o_Halt_Req     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed scoreboard bench for test_status_monitor (default and 2-bit-counter instances).
module tb_test_status_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0, adv = 1'b0, rdy = 1'b0;
  logic [1:0]  code = 2'd0;
  logic [15:0] val = 16'd0;

  logic        a_rv, a_failed, a_ovf, a_done, a_halt;
  logic [1:0]  a_rc;
  logic [15:0] a_rval, a_pass, a_fail;
  logic        b_rv, b_failed, b_ovf, b_done, b_halt;
  logic [1:0]  b_rc, b_pass, b_fail;
  logic [15:0] b_rval;

  int n_chk = 0, n_pass = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  test_status_monitor #(.DEPTH(4), .COUNT_WIDTH(16)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(vld), .i_Advance(adv),
    .i_Pass_Done_Change(code), .i_Pass_Done_Value(val),
    .o_Report_Valid(a_rv), .o_Report_Code(a_rc), .o_Report_Value(a_rval),
    .i_Report_Ready(rdy), .o_Pass_Count(a_pass), .o_Fail_Count(a_fail),
    .o_Failed(a_failed), .o_Overflow(a_ovf), .o_Done(a_done), .o_Halt_Req(a_halt));

  test_status_monitor #(.DEPTH(4), .COUNT_WIDTH(2)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(vld), .i_Advance(adv),
    .i_Pass_Done_Change(code), .i_Pass_Done_Value(val),
    .o_Report_Valid(b_rv), .o_Report_Code(b_rc), .o_Report_Value(b_rval),
    .i_Report_Ready(rdy), .o_Pass_Count(b_pass), .o_Fail_Count(b_fail),
    .o_Failed(b_failed), .o_Overflow(b_ovf), .o_Done(b_done), .o_Halt_Req(b_halt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every handshake on the report port consumes one expected entry.
  always @(negedge clk) begin
    if (!rst && a_rv && rdy) begin
      if (exp_q.size() == 0) chk("unexpected_report", {14'd0, a_rc, a_rval}, 32'h0);
      else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        chk("report", {14'd0, a_rc, a_rval}, {14'd0, e});
      end
    end
  end

  task automatic ev(input logic [1:0] c, input logic [15:0] v, input logic a);
    vld = 1'b1; code = c; val = v; adv = a;
    @(posedge clk); #1;
    vld = 1'b0; code = 2'd0; val = 16'd0; adv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_rv"}, a_rv, 0);
    chk({name, "_head"}, {14'd0, a_rc, a_rval}, 0);
    chk({name, "_cnt"}, {a_pass, a_fail}, 0);
    chk({name, "_flags"}, {a_failed, a_ovf, a_done, a_halt}, 0);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;

    // Basic pass: halt rises after the edge that pops DONE.
    rdy = 1'b1;
    exp_q.push_back({2'd1, 16'h0005});
    exp_q.push_back({2'd3, 16'h0000});
    ev(2'd1, 16'h0005, 1'b1);
    ev(2'd3, 16'h0000, 1'b1);
    @(negedge clk);
    chk("basic_halt_early", a_halt, 0);
    chk("basic_done", a_done, 1);
    @(negedge clk);
    chk("basic_halt", a_halt, 1);
    chk("basic_pass_cnt", a_pass, 1);
    drain("basic");

    // Stall filtering.
    do_reset();
    exp_q.push_back({2'd2, 16'h0003});
    repeat (3) ev(2'd2, 16'h0003, 1'b0);
    ev(2'd2, 16'h0003, 1'b1);
    drain("stall");
    chk("stall_fail_cnt", a_fail, 1);
    chk("stall_failed", a_failed, 1);

    // Overflow: only the first four of six survive.
    do_reset();
    rdy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) exp_q.push_back({2'd1, 16'(i)});
      ev(2'd1, 16'(i), 1'b1);
    end
    @(negedge clk);
    chk("ovf_flag", a_ovf, 1);
    chk("ovf_pass_cnt", a_pass, 6);
    chk("ovf_head_stable", {14'd0, a_rc, a_rval}, {14'd0, 2'd1, 16'd1});
    @(posedge clk); #1;
    rdy = 1'b1;
    drain("ovf");

    // Full FIFO with simultaneous push and pop.
    do_reset();
    rdy = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      exp_q.push_back({2'd1, 16'(i)});
      ev(2'd1, 16'(i), 1'b1);
    end
    rdy = 1'b1;
    exp_q.push_back({2'd1, 16'd14});
    ev(2'd1, 16'd14, 1'b1);
    drain("fullpp");
    chk("fullpp_ovf", a_ovf, 0);
    chk("fullpp_pass_cnt", a_pass, 5);

    // Saturation (2-bit instance) and events ignored after DONE.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({2'd1, 16'(i)});
      ev(2'd1, 16'(i), 1'b1);
    end
    exp_q.push_back({2'd2, 16'd7});
    ev(2'd2, 16'd7, 1'b1);
    exp_q.push_back({2'd3, 16'd0});
    ev(2'd3, 16'd0, 1'b1);
    ev(2'd2, 16'd8, 1'b1);
    drain("sat");
    chk("sat_b_pass", b_pass, 3);
    chk("sat_b_fail", b_fail, 1);
    chk("sat_b_failed", b_failed, 1);
    chk("sat_a_pass", a_pass, 5);
    chk("sat_a_fail", a_fail, 1);
    chk("sat_a_halt", a_halt, 1);

    // Reset in the middle of a drain discards queued entries.
    do_reset();
    rdy = 1'b0;
    ev(2'd1, 16'd1, 1'b1);
    ev(2'd1, 16'd2, 1'b1);
    ev(2'd3, 16'd0, 1'b1);
    @(negedge clk);
    chk("mid_done", a_done, 1);
    chk("mid_halt", a_halt, 0);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk_idle("mid_reset");
    @(posedge clk); #1;
    rdy = 1'b1;
    exp_q.push_back({2'd1, 16'h0009});
    ev(2'd1, 16'h0009, 1'b1);
    drain("mid_after");
    chk("mid_after_pass", a_pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
